uart_cmd_decoder: RTL and testbench

Sits directly downstream of the UART receiver and consumes its `byteReady`/`dataIn` pair. It assembles fixed-length 8-byte command frames into validated commands: sync, opcode, 24-bit address, 16-bit length and XOR checksum. Each valid command is presented to the flash-dump controller over a valid/ready handshake. Malformed or truncated frames are dropped and reported as a one-cycle error pulse.

---
 rtl/uart_cmd_pkg.sv | 34 +++
 rtl/uart_cmd_decoder_if.sv | 25 ++
 rtl/uart_byte_strobe.sv | 34 +++
 rtl/uart_cmd_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared opcode, error-code and state definitions for the UART command decoder.
// No logic; constants and types only.
// Imported by the decoder, the byte strobe and the command interface.
package uart_cmd_pkg;

    localparam logic [7:0] OP_READ = 8'h52;
    localparam logic [7:0] OP_PING = 8'h50;

    localparam logic [2:0] ERR_CHECKSUM = 3'd1;
    localparam logic [2:0] ERR_OPCODE   = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_OVERRUN  = 3'd4;

    // SYNC, OP, A2, A1, A0, L1, L0, CK
    localparam int FRAME_LEN = 8;

    typedef enum logic [3:0] {
        IDLE,
        OPCODE,
        ADDR2,
        ADDR1,
        ADDR0,
        LEN1,
        LEN0,
        CHECK,
        PENDING
    } cmdState_t;

    // PING carries any addr/len; READ must request at least one byte.
    function automatic logic isValidCmd(input logic [7:0] op, input logic [15:0] len);
        return (op == OP_PING) || ((op == OP_READ) && (len != 16'h0000));
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Command and error channel between the decoder and the flash-dump controller.
// Latency: wires only.
// Backpressure: cmdValid held by the master until cmdValid && cmdReady; err is a pulse.
interface uart_cmd_if;
    import uart_cmd_pkg::*;

    logic        cmdValid;
    logic        cmdReady;
    logic [7:0]  cmdOp;
    logic [23:0] cmdAddr;
    logic [15:0] cmdLen;
    logic        errValid;
    logic [2:0]  errCode;

    modport master (
        output cmdValid, cmdOp, cmdAddr, cmdLen, errValid, errCode,
        input  cmdReady
    );

    modport slave (
        input  cmdValid, cmdOp, cmdAddr, cmdLen, errValid, errCode,
        output cmdReady
    );

endinterface

// File: rtl/uart_byte_strobe.sv
// Turns the UART rx byteReady level into a single-cycle strobe with the byte captured.
// Latency: 1 clk from the byteReady rising edge to byteStrobe/byteData.
// Backpressure: none; every rising edge yields exactly one strobe.
module uart_byte_strobe (
    input  logic       clk,
    input  logic       resetN,
    input  logic       byteReady,
    input  logic [7:0] dataIn,
    output logic       byteStrobe,
    output logic [7:0] byteData
);
    import uart_cmd_pkg::*;

    logic byteReadyPrev;
    logic riseEdge;

    assign riseEdge = byteReady & ~byteReadyPrev;

    // History resets to 1 so a level already high at reset release is not a new byte.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            byteReadyPrev <= 1'b1;
            byteStrobe    <= 1'b0;
            byteData      <= 8'h00;
        end else begin
            byteReadyPrev <= byteReady;
            byteStrobe    <= riseEdge;
            if (riseEdge) begin
                byteData <= dataIn;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles 8-byte UART frames (SYNC OP A2 A1 A0 L1 L0 CK) into validated commands.
// Latency: cmdValid rises 1 clk after the checksum byte strobe; errors pulse 1 clk after detection.
// Backpressure: command held until cmdReady; a byte arriving while held is dropped as overrun.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 27000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       byteReady,
    input  logic [7:0] dataIn,
    uart_cmd_if.master cmd
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    cmdState_t   state, nextState;
    logic        byteStrobe;
    logic [7:0]  byteData;

    logic [CNT_W-1:0] timeoutCnt;
    logic [7:0]  opReg;
    logic [23:0] addrReg;
    logic [15:0] lenReg;
    logic [7:0]  xorReg;

    logic        inFrame;
    logic        timeoutHit;
    logic        errFire;
    logic [2:0]  errSel;
    logic        loadCmd;
    logic        handshake;

    uart_byte_strobe uStrobe (
        .clk        (clk),
        .resetN     (resetN),
        .byteReady  (byteReady),
        .dataIn     (dataIn),
        .byteStrobe (byteStrobe),
        .byteData   (byteData)
    );

    assign inFrame    = (state == OPCODE) || (state == ADDR2) || (state == ADDR1) ||
                        (state == ADDR0)  || (state == LEN1)  || (state == LEN0)  ||
                        (state == CHECK);
    assign timeoutHit = inFrame && !byteStrobe && (timeoutCnt == CNT_LAST);
    assign handshake  = cmd.cmdValid && cmd.cmdReady;

    // Frame state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode, error selection and command load; a strobe always beats timeout.
    always_comb begin
        nextState = state;
        errFire   = 1'b0;
        errSel    = ERR_CHECKSUM;
        loadCmd   = 1'b0;
        unique case (state)
            IDLE: begin
                if (byteStrobe && (byteData == SYNC_BYTE)) begin
                    nextState = OPCODE;
                end
            end
            OPCODE, ADDR2, ADDR1, ADDR0, LEN1, LEN0: begin
                if (byteStrobe) begin
                    nextState = cmdState_t'(state + 4'd1);
                end else if (timeoutHit) begin
                    nextState = IDLE;
                    errFire   = 1'b1;
                    errSel    = ERR_TIMEOUT;
                end
            end
            CHECK: begin
                if (byteStrobe) begin
                    if (byteData != xorReg) begin
                        nextState = IDLE;
                        errFire   = 1'b1;
                        errSel    = ERR_CHECKSUM;
                    end else if (!isValidCmd(opReg, lenReg)) begin
                        nextState = IDLE;
                        errFire   = 1'b1;
                        errSel    = ERR_OPCODE;
                    end else begin
                        nextState = PENDING;
                        loadCmd   = 1'b1;
                    end
                end else if (timeoutHit) begin
                    nextState = IDLE;
                    errFire   = 1'b1;
                    errSel    = ERR_TIMEOUT;
                end
            end
            PENDING: begin
                if (handshake) begin
                    // A byte coinciding with acceptance is treated as an IDLE byte.
                    if (byteStrobe && (byteData == SYNC_BYTE)) begin
                        nextState = OPCODE;
                    end else begin
                        nextState = IDLE;
                    end
                end else if (byteStrobe) begin
                    errFire = 1'b1;
                    errSel  = ERR_OVERRUN;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Inter-byte timeout counter; only counts while a frame is partially received.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            timeoutCnt <= '0;
        end else if (byteStrobe || !inFrame) begin
            timeoutCnt <= '0;
        end else begin
            timeoutCnt <= timeoutCnt + 1'b1;
        end
    end

    // Field shift registers and running XOR over OP..L0.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            opReg   <= 8'h00;
            addrReg <= 24'h000000;
            lenReg  <= 16'h0000;
            xorReg  <= 8'h00;
        end else if (byteStrobe) begin
            unique case (state)
                OPCODE: begin
                    opReg  <= byteData;
                    xorReg <= byteData;
                end
                ADDR2: begin
                    addrReg[23:16] <= byteData;
                    xorReg         <= xorReg ^ byteData;
                end
                ADDR1: begin
                    addrReg[15:8] <= byteData;
                    xorReg        <= xorReg ^ byteData;
                end
                ADDR0: begin
                    addrReg[7:0] <= byteData;
                    xorReg       <= xorReg ^ byteData;
                end
                LEN1: begin
                    lenReg[15:8] <= byteData;
                    xorReg       <= xorReg ^ byteData;
                end
                LEN0: begin
                    lenReg[7:0] <= byteData;
                    xorReg      <= xorReg ^ byteData;
                end
                default: begin
                end
            endcase
        end
    end

    // Command output holding registers; frozen while cmdValid is high.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cmd.cmdValid <= 1'b0;
            cmd.cmdOp    <= 8'h00;
            cmd.cmdAddr  <= 24'h000000;
            cmd.cmdLen   <= 16'h0000;
        end else if (loadCmd) begin
            cmd.cmdValid <= 1'b1;
            cmd.cmdOp    <= opReg;
            cmd.cmdAddr  <= addrReg;
            cmd.cmdLen   <= lenReg;
        end else if (handshake) begin
            cmd.cmdValid <= 1'b0;
        end
    end

    // Registered one-cycle error pulse; the code persists between pulses.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cmd.errValid <= 1'b0;
            cmd.errCode  <= 3'd0;
        end else begin
            cmd.errValid <= errFire;
            if (errFire) begin
                cmd.errCode <= errSel;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with hand-computed expected frames.
// Latency: n/a.
// Backpressure: exercised through cmdReady.
module tb_uart_cmd_decoder;

    localparam int TIMEOUT = 27000;

    logic       clk;
    logic       resetN;
    logic       byteReady;
    logic [7:0] dataIn;

    uart_cmd_if ifc ();

    uart_cmd_decoder #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .byteReady (byteReady),
        .dataIn    (dataIn),
        .cmd       (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecCnt  = 0;
    int missCnt = 0;

    logic [2:0]  errQ[$];
    logic [47:0] cmdQ[$];
    int          validCycles;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (ifc.errValid) errQ.push_back(ifc.errCode);
        if (ifc.cmdValid) validCycles++;
        if (ifc.cmdValid && ifc.cmdReady) cmdQ.push_back({ifc.cmdOp, ifc.cmdAddr, ifc.cmdLen});
    end

    task automatic checkVal(input string tag, input logic [47:0] got, input logic [47:0] exp);
        vecCnt++;
        if (got !== exp) begin
            missCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearObs();
        errQ.delete();
        cmdQ.delete();
        validCycles = 0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(posedge clk); #1;
        dataIn    = b;
        byteReady = 1'b1;
        repeat (3) @(posedge clk);
        #1 byteReady = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] op, input logic [23:0] addr,
                             input logic [15:0] len, input logic [7:0] ck);
        sendByte(8'hA5);
        sendByte(op);
        sendByte(addr[23:16]);
        sendByte(addr[15:8]);
        sendByte(addr[7:0]);
        sendByte(len[15:8]);
        sendByte(len[7:0]);
        sendByte(ck);
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    logic [7:0] pingBytes [10];

    initial begin
        resetN    = 1'b0;
        byteReady = 1'b1;     // level already high across reset release
        dataIn    = 8'hA5;
        ifc.cmdReady = 1'b1;
        validCycles  = 0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rstValid", {47'd0, ifc.cmdValid}, 48'd0);
        checkVal("rstErrV",  {47'd0, ifc.errValid}, 48'd0);
        checkVal("rstErrC",  {45'd0, ifc.errCode}, 48'd0);
        checkVal("rstFields", {ifc.cmdOp, ifc.cmdAddr, ifc.cmdLen}, 48'd0);
        resetN = 1'b1;
        repeat (5) @(posedge clk);
        #1 byteReady = 1'b0;
        clearObs();

        // Held-high A5 must not count as SYNC: the following bytes form no frame.
        sendByte(8'h52); sendByte(8'h01); sendByte(8'h23); sendByte(8'h45);
        sendByte(8'h00); sendByte(8'h10); sendByte(8'h25);
        settle();
        checkVal("noStaleSync", cmdQ.size(), 48'd0);
        checkVal("noStaleErr",  errQ.size(), 48'd0);

        // Valid READ frame, consumer ready.
        clearObs();
        sendFrame(8'h52, 24'h012345, 16'h0010, 8'h25);
        settle();
        checkVal("readCnt",   cmdQ.size(), 48'd1);
        if (cmdQ.size() > 0) checkVal("readCmd", cmdQ[0], 48'h52_012345_0010);
        checkVal("readValid1", validCycles, 48'd1);
        checkVal("readNoErr", errQ.size(), 48'd0);

        // Bad checksum, then recovery.
        clearObs();
        sendFrame(8'h52, 24'h012345, 16'h0010, 8'h24);
        settle();
        checkVal("ckErrCnt", errQ.size(), 48'd1);
        if (errQ.size() > 0) checkVal("ckErrCode", errQ[0], 48'd1);
        checkVal("ckNoCmd", cmdQ.size(), 48'd0);
        clearObs();
        sendFrame(8'h52, 24'h012345, 16'h0010, 8'h25);
        settle();
        checkVal("ckRecover", cmdQ.size(), 48'd1);
        if (cmdQ.size() > 0) checkVal("ckRecoverCmd", cmdQ[0], 48'h52_012345_0010);

        // Leading junk then PING.
        clearObs();
        pingBytes = '{8'h00, 8'hFF, 8'hA5, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h50};
        foreach (pingBytes[i]) sendByte(pingBytes[i]);
        settle();
        checkVal("pingCnt", cmdQ.size(), 48'd1);
        if (cmdQ.size() > 0) checkVal("pingCmd", cmdQ[0], 48'h50_000000_0000);
        checkVal("pingNoErr", errQ.size(), 48'd0);

        // Truncated frame times out exactly once.
        clearObs();
        sendByte(8'hA5); sendByte(8'h52); sendByte(8'h01);
        for (int i = 0; i < TIMEOUT + 100 && errQ.size() == 0; i++) @(posedge clk);
        repeat (200) @(posedge clk);
        checkVal("tmoCnt", errQ.size(), 48'd1);
        if (errQ.size() > 0) checkVal("tmoCode", errQ[0], 48'd3);
        checkVal("tmoNoCmd", cmdQ.size(), 48'd0);
        clearObs();
        sendFrame(8'h52, 24'h0A0B0C, 16'h0100, 8'h52 ^ 8'h0A ^ 8'h0B ^ 8'h0C ^ 8'h01);
        settle();
        checkVal("tmoRecover", cmdQ.size(), 48'd1);
        if (cmdQ.size() > 0) checkVal("tmoRecoverCmd", cmdQ[0], 48'h52_0A0B0C_0100);

        // Overrun while a command is held.
        clearObs();
        ifc.cmdReady = 1'b0;
        sendFrame(8'h52, 24'h012345, 16'h0010, 8'h25);
        settle();
        checkVal("holdValid", {47'd0, ifc.cmdValid}, 48'd1);
        sendByte(8'h33);
        settle();
        checkVal("ovrErrCnt", errQ.size(), 48'd1);
        if (errQ.size() > 0) checkVal("ovrErrCode", errQ[0], 48'd4);
        checkVal("ovrStillValid", {47'd0, ifc.cmdValid}, 48'd1);
        checkVal("ovrFields", {ifc.cmdOp, ifc.cmdAddr, ifc.cmdLen}, 48'h52_012345_0010);
        ifc.cmdReady = 1'b1;
        settle();
        checkVal("ovrAccept", cmdQ.size(), 48'd1);
        if (cmdQ.size() > 0) checkVal("ovrAcceptCmd", cmdQ[0], 48'h52_012345_0010);
        checkVal("ovrDropped", {47'd0, ifc.cmdValid}, 48'd0);

        // Zero-length READ and unknown opcode.
        clearObs();
        sendFrame(8'h52, 24'h010203, 16'h0000, 8'h52);
        settle();
        checkVal("zeroLenCnt", errQ.size(), 48'd1);
        if (errQ.size() > 0) checkVal("zeroLenCode", errQ[0], 48'd2);
        clearObs();
        sendFrame(8'h11, 24'h000000, 16'h0001, 8'h10);
        settle();
        checkVal("badOpCnt", errQ.size(), 48'd1);
        if (errQ.size() > 0) checkVal("badOpCode", errQ[0], 48'd2);
        checkVal("badOpNoCmd", cmdQ.size(), 48'd0);
        checkVal("errCodeHeld", {45'd0, ifc.errCode}, 48'd2);

        // Reset mid-frame: outputs cleared, no error.
        clearObs();
        sendByte(8'hA5); sendByte(8'h52); sendByte(8'h01); sendByte(8'h23);
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("midRstValid", {47'd0, ifc.cmdValid}, 48'd0);
        checkVal("midRstErrC",  {45'd0, ifc.errCode}, 48'd0);
        resetN = 1'b1;
        repeat (100) @(posedge clk);
        checkVal("midRstNoErr", errQ.size(), 48'd0);

        // Reset while a command is pending drops it silently.
        clearObs();
        ifc.cmdReady = 1'b0;
        sendFrame(8'h50, 24'h000001, 16'h0002, 8'h50 ^ 8'h01 ^ 8'h02);
        settle();
        checkVal("pendValid", {47'd0, ifc.cmdValid}, 48'd1);
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        ifc.cmdReady = 1'b1;
        settle();
        checkVal("pendLostValid", {47'd0, ifc.cmdValid}, 48'd0);
        checkVal("pendLostCmd",  cmdQ.size(), 48'd0);
        checkVal("pendLostErr",  errQ.size(), 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
